// File: rtl/ghost_pkg.sv
// Shared ghost constants: coordinate and direction widths, one-hot direction codes,
// scheduler FSM encoding and small distance helpers.
// Used by the direction engine, pacman logic and the move scheduler alike.
package ghost_pkg;

    localparam int POS_X_W = 11;
    localparam int POS_Y_W = 10;
    localparam int DIR_W   = 4;

    typedef logic [POS_X_W-1:0] pos_x_t;
    typedef logic [POS_Y_W-1:0] pos_y_t;
    typedef logic [DIR_W-1:0]   dir_t;

    // One-hot direction codes; anything else means "no move".
    localparam dir_t DIR_NONE  = 4'b0000;
    localparam dir_t DIR_RIGHT = 4'b0001;
    localparam dir_t DIR_UP    = 4'b0010;
    localparam dir_t DIR_DOWN  = 4'b0100;
    localparam dir_t DIR_LEFT  = 4'b1000;

    // Scheduler FSM encoding.
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD    = 3'd1;
    localparam logic [STATE_W-1:0] ST_STEP    = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT    = 3'd3;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;

    // Unsigned |a-b|, larger operand always the minuend so nothing wraps.
    function automatic pos_x_t abs_diff_x(input pos_x_t a, input pos_x_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic pos_y_t abs_diff_y(input pos_y_t a, input pos_y_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ghost_pos_step.sv
// Purpose : next position of one ghost for a requested direction, clamped to the playfield.
// Latency : combinational.
// Ports   : x/y/dir in; next_x/next_y out; dir_valid high only for a one-hot direction.
module ghost_pos_step
    import ghost_pkg::*;
#(
    parameter int unsigned STEP_PX = 1,
    parameter pos_x_t      X_MAX   = 11'd639,
    parameter pos_y_t      Y_MAX   = 10'd479
) (
    input  logic [POS_X_W-1:0] x,
    input  logic [POS_Y_W-1:0] y,
    input  logic [DIR_W-1:0]   dir,
    output logic [POS_X_W-1:0] next_x,
    output logic [POS_Y_W-1:0] next_y,
    output logic               dir_valid
);

    localparam pos_x_t STEP_X = pos_x_t'(STEP_PX);
    localparam pos_y_t STEP_Y = pos_y_t'(STEP_PX);
    // Any coordinate at or beyond these edges would step past the max, so it pins to the max.
    localparam pos_x_t X_EDGE = X_MAX - STEP_X;
    localparam pos_y_t Y_EDGE = Y_MAX - STEP_Y;

    always_comb begin
        next_x    = x;
        next_y    = y;
        dir_valid = 1'b0;
        case (dir)
            DIR_RIGHT: begin
                dir_valid = 1'b1;
                next_x    = (x >= X_EDGE) ? X_MAX : (x + STEP_X);
            end
            DIR_LEFT: begin
                dir_valid = 1'b1;
                next_x    = (x <= STEP_X) ? '0 : (x - STEP_X);
            end
            // Screen coordinates: up decreases y.
            DIR_UP: begin
                dir_valid = 1'b1;
                next_y    = (y <= STEP_Y) ? '0 : (y - STEP_Y);
            end
            DIR_DOWN: begin
                dir_valid = 1'b1;
                next_y    = (y >= Y_EDGE) ? Y_MAX : (y + STEP_Y);
            end
            default: begin
                dir_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ghost_move_scheduler.sv
// Purpose : time-multiplexes one direction engine over NUM_GHOSTS ghosts per move tick;
//           owns ghost position/direction state and flags pacman capture.
// Latency : NUM_GHOSTS*(2+2*DIR_LATENCY)+1 cycles from tick to done.
// Ports   : tick/respawn/pacman in; eng_* engine handshake; packed ghost state,
//           busy/done/caught/overrun status out. Ticks while busy are dropped and set overrun.
module ghost_move_scheduler
    import ghost_pkg::*;
#(
    parameter int unsigned NUM_GHOSTS  = 4,
    parameter int unsigned DIR_LATENCY = 2,
    parameter int unsigned STEP_PX     = 1,
    parameter pos_x_t      X_MAX       = 11'd639,
    parameter pos_y_t      Y_MAX       = 10'd479,
    parameter pos_x_t      HOME_X      = 11'd304,
    parameter pos_y_t      HOME_Y      = 10'd224,
    parameter int unsigned HIT_RADIUS  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tick,
    input  logic                            respawn,
    input  logic [POS_X_W-1:0]              pacman_x,
    input  logic [POS_Y_W-1:0]              pacman_y,
    output logic [POS_X_W-1:0]              eng_ghost_x,
    output logic [POS_Y_W-1:0]              eng_ghost_y,
    output logic [DIR_W-1:0]                eng_prev_dir,
    output logic                            eng_step,
    input  logic [DIR_W-1:0]                eng_dir,
    output logic [POS_X_W*NUM_GHOSTS-1:0]   ghost_x,
    output logic [POS_Y_W*NUM_GHOSTS-1:0]   ghost_y,
    output logic [DIR_W*NUM_GHOSTS-1:0]     ghost_dir,
    output logic                            busy,
    output logic                            done,
    output logic                            caught,
    output logic                            overrun
);

    localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int CNT_W = $clog2(DIR_LATENCY + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_GHOSTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIR_LATENCY);
    localparam pos_x_t HIT_X = pos_x_t'(HIT_RADIUS);
    localparam pos_y_t HIT_Y = pos_y_t'(HIT_RADIUS);

    logic [STATE_W-1:0] state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;

    pos_x_t gx [NUM_GHOSTS];
    pos_y_t gy [NUM_GHOSTS];
    dir_t   gd [NUM_GHOSTS];

    pos_x_t step_x;
    pos_y_t step_y;
    logic   step_valid;
    logic   any_hit;

    // Ghost i starts 16 px to the right of ghost i-1.
    function automatic pos_x_t home_x(input int g);
        return pos_x_t'(HOME_X + 16 * g);
    endfunction

    ghost_pos_step #(
        .STEP_PX (STEP_PX),
        .X_MAX   (X_MAX),
        .Y_MAX   (Y_MAX)
    ) u_pos_step (
        .x         (gx[idx]),
        .y         (gy[idx]),
        .dir       (eng_dir),
        .next_x    (step_x),
        .next_y    (step_y),
        .dir_valid (step_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            cnt          <= '0;
            eng_ghost_x  <= '0;
            eng_ghost_y  <= '0;
            eng_prev_dir <= '0;
            overrun      <= 1'b0;
            for (int g = 0; g < int'(NUM_GHOSTS); g++) begin
                gx[g] <= home_x(g);
                gy[g] <= HOME_Y;
                gd[g] <= DIR_NONE;
            end
        end else if (respawn) begin
            // Respawn beats everything, including a same-cycle tick.
            state        <= ST_IDLE;
            idx          <= '0;
            cnt          <= '0;
            eng_ghost_x  <= '0;
            eng_ghost_y  <= '0;
            eng_prev_dir <= '0;
            overrun      <= 1'b0;
            for (int g = 0; g < int'(NUM_GHOSTS); g++) begin
                gx[g] <= home_x(g);
                gy[g] <= HOME_Y;
                gd[g] <= DIR_NONE;
            end
        end else begin
            if (tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Engine inputs stay frozen from here until CAPTURE finishes.
                    eng_ghost_x  <= gx[idx];
                    eng_ghost_y  <= gy[idx];
                    eng_prev_dir <= gd[idx];
                    cnt          <= '0;
                    state        <= ST_STEP;
                end
                ST_STEP: begin
                    cnt   <= cnt + 1'b1;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    state <= (cnt < CNT_LAST) ? ST_STEP : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Invalid directions leave both position and last direction untouched.
                    if (step_valid) begin
                        gx[idx] <= step_x;
                        gy[idx] <= step_y;
                        gd[idx] <= eng_dir;
                    end
                    if (idx == IDX_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    idx   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture test runs on the live register file; in DONE it already holds the final sweep result.
    always_comb begin
        any_hit = 1'b0;
        for (int g = 0; g < int'(NUM_GHOSTS); g++) begin
            if ((abs_diff_x(gx[g], pacman_x) < HIT_X) && (abs_diff_y(gy[g], pacman_y) < HIT_Y)) begin
                any_hit = 1'b1;
            end
        end
    end

    assign eng_step = (state == ST_STEP);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign caught   = done & any_hit;

    for (genvar g = 0; g < int'(NUM_GHOSTS); g++) begin : g_pack
        assign ghost_x[g*POS_X_W +: POS_X_W] = gx[g];
        assign ghost_y[g*POS_Y_W +: POS_Y_W] = gy[g];
        assign ghost_dir[g*DIR_W +: DIR_W]   = gd[g];
    end

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Bench for ghost_move_scheduler: the bench plays the direction engine, keeps its own
// picture of every ghost, and compares the DUT against it after each sweep.
module tb_ghost_move_scheduler;

    localparam int NG  = 4;
    localparam int DL  = 2;
    localparam int XM  = 639;
    localparam int YM  = 479;
    localparam int HR  = 8;
    localparam int SWEEP_LAT = NG * (2 + 2 * DL) + 1;

    logic            clk;
    logic            rst;
    logic            tick;
    logic            respawn;
    logic [10:0]     pacman_x;
    logic [9:0]      pacman_y;
    logic [10:0]     eng_ghost_x;
    logic [9:0]      eng_ghost_y;
    logic [3:0]      eng_prev_dir;
    logic            eng_step;
    logic [3:0]      eng_dir = 4'b0000;
    logic [11*NG-1:0] ghost_x;
    logic [10*NG-1:0] ghost_y;
    logic [4*NG-1:0]  ghost_dir;
    logic            busy;
    logic            done;
    logic            caught;
    logic            overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference picture of the ghosts (current) and a snapshot from the start of the sweep.
    int mx [NG];
    int my [NG];
    int md [NG];
    int ox [NG];
    int oy [NG];
    int od [NG];
    logic [3:0] plan [NG];
    int  pulse_cnt = 0;
    bit  chk_eng   = 1'b0;
    bit  last_caught;

    typedef struct {
        logic [3:0] dir;
        int         px;
        int         py;
        int         ex0;
        int         ey0;
        int         ed0;
        bit         ec;
    } vec_t;

    vec_t tbl [6];

    ghost_move_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .respawn      (respawn),
        .pacman_x     (pacman_x),
        .pacman_y     (pacman_y),
        .eng_ghost_x  (eng_ghost_x),
        .eng_ghost_y  (eng_ghost_y),
        .eng_prev_dir (eng_prev_dir),
        .eng_step     (eng_step),
        .eng_dir      (eng_dir),
        .ghost_x      (ghost_x),
        .ghost_y      (ghost_y),
        .ghost_dir    (ghost_dir),
        .busy         (busy),
        .done         (done),
        .caught       (caught),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit dir_ok(input logic [3:0] d);
        return (d == 4'b0001) || (d == 4'b0010) || (d == 4'b0100) || (d == 4'b1000);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_home();
        for (int g = 0; g < NG; g++) begin
            mx[g] = 304 + 16 * g;
            my[g] = 224;
            md[g] = 0;
        end
    endtask

    // One granted move per ghost; coordinates saturate at the playfield edges.
    task automatic model_apply();
        for (int g = 0; g < NG; g++) begin
            case (plan[g])
                4'b0001: mx[g] = (mx[g] + 1 > XM) ? XM : mx[g] + 1;
                4'b1000: mx[g] = (mx[g] - 1 < 0) ? 0 : mx[g] - 1;
                4'b0010: my[g] = (my[g] - 1 < 0) ? 0 : my[g] - 1;
                4'b0100: my[g] = (my[g] + 1 > YM) ? YM : my[g] + 1;
                default: ;
            endcase
            if (dir_ok(plan[g])) md[g] = int'(plan[g]);
        end
    endtask

    function automatic bit model_caught(input int px, input int py);
        bit c = 1'b0;
        for (int g = 0; g < NG; g++)
            if (iabs(mx[g] - px) < HR && iabs(my[g] - py) < HR) c = 1'b1;
        return c;
    endfunction

    task automatic chk_all(input string tag);
        for (int g = 0; g < NG; g++) begin
            chk($sformatf("%s_x%0d", tag, g), int'(ghost_x[g*11 +: 11]), mx[g]);
            chk($sformatf("%s_y%0d", tag, g), int'(ghost_y[g*10 +: 10]), my[g]);
            chk($sformatf("%s_d%0d", tag, g), int'(ghost_dir[g*4 +: 4]), md[g]);
        end
    endtask

    task automatic fill_plan(input logic [3:0] d);
        for (int g = 0; g < NG; g++) plan[g] = d;
    endtask

    task automatic do_respawn();
        respawn = 1'b1;
        @(negedge clk);
        respawn = 1'b0;
        model_home();
    endtask

    // The bench acts as the direction engine: on each step pulse it checks the presented
    // ghost against the sweep-start snapshot and drives that ghost's planned answer.
    always @(negedge clk) begin
        int eg;
        if (eng_step) begin
            eg = pulse_cnt / DL;
            if (eg < NG) begin
                if (chk_eng) begin
                    chk("eng_ghost_x", int'(eng_ghost_x), ox[eg]);
                    chk("eng_ghost_y", int'(eng_ghost_y), oy[eg]);
                    chk("eng_prev_dir", int'(eng_prev_dir), od[eg]);
                end
                eng_dir = plan[eg];
            end
            pulse_cnt++;
        end
    end

    // One full tick-to-done sweep, called and returning at a falling edge.
    task automatic run_sweep(input bit check);
        int lat;
        bit exp_c;
        for (int g = 0; g < NG; g++) begin
            ox[g] = mx[g];
            oy[g] = my[g];
            od[g] = md[g];
        end
        model_apply();
        exp_c     = model_caught(int'(pacman_x), int'(pacman_y));
        pulse_cnt = 0;
        chk_eng   = check;
        tick      = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        lat  = 1;
        if (check) chk("busy_after_tick", busy, 1);
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", done, 1);
        last_caught = caught;
        if (check && done) begin
            chk("tick_to_done", lat, SWEEP_LAT);
            chk("step_pulses", pulse_cnt, NG * DL);
            chk("caught", caught, exp_c);
        end
        @(negedge clk);
        chk_eng = 1'b0;
        if (check) begin
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
            chk_all("sweep");
        end
    endtask

    initial begin
        int dn;
        tbl[0] = '{dir: 4'b0001, px: 310, py: 226, ex0: 305, ey0: 224, ed0: 1, ec: 1'b1};
        tbl[1] = '{dir: 4'b1000, px: 0,   py: 0,   ex0: 303, ey0: 224, ed0: 8, ec: 1'b0};
        tbl[2] = '{dir: 4'b0010, px: 304, py: 231, ex0: 304, ey0: 223, ed0: 2, ec: 1'b0};
        tbl[3] = '{dir: 4'b0100, px: 304, py: 231, ex0: 304, ey0: 225, ed0: 4, ec: 1'b1};
        tbl[4] = '{dir: 4'b0110, px: 311, py: 224, ex0: 304, ey0: 224, ed0: 0, ec: 1'b1};
        tbl[5] = '{dir: 4'b0000, px: 296, py: 224, ex0: 304, ey0: 224, ed0: 0, ec: 1'b0};

        rst      = 1'b0;
        tick     = 1'b0;
        respawn  = 1'b0;
        pacman_x = '0;
        pacman_y = '0;
        fill_plan(4'b0001);
        model_home();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_caught", caught, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_eng_step", eng_step, 0);
        chk("rst_eng_x", int'(eng_ghost_x), 0);
        chk("rst_eng_y", int'(eng_ghost_y), 0);
        chk("rst_eng_dir", int'(eng_prev_dir), 0);
        chk_all("rst");
        rst = 1'b1;
        @(negedge clk);

        // Table: one sweep from home per direction pattern
        for (int i = 0; i < 6; i++) begin
            do_respawn();
            fill_plan(tbl[i].dir);
            pacman_x = 11'(tbl[i].px);
            pacman_y = 10'(tbl[i].py);
            run_sweep(1'b1);
            chk($sformatf("tbl%0d_x0", i), int'(ghost_x[10:0]), tbl[i].ex0);
            chk($sformatf("tbl%0d_y0", i), int'(ghost_y[9:0]), tbl[i].ey0);
            chk($sformatf("tbl%0d_d0", i), int'(ghost_dir[3:0]), tbl[i].ed0);
            chk($sformatf("tbl%0d_caught", i), last_caught, tbl[i].ec);
        end

        // Invalid direction keeps the previous direction
        pacman_x = '0;
        pacman_y = '0;
        do_respawn();
        fill_plan(4'b0001);
        run_sweep(1'b1);
        fill_plan(4'b0110);
        run_sweep(1'b1);
        chk("invalid_hold_dir0", int'(ghost_dir[3:0]), 1);
        chk("invalid_hold_x0", int'(ghost_x[10:0]), 305);

        // Second tick 5 cycles into a sweep
        do_respawn();
        chk("overrun_clear_pre", overrun, 0);
        fill_plan(4'b0001);
        model_apply();
        pulse_cnt = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("overrun_set", overrun, 1);
        dn = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("overrun_one_done", dn, 1);
        chk_all("overrun");
        chk("overrun_sticky", overrun, 1);
        do_respawn();
        chk("overrun_cleared", overrun, 0);

        // Respawn during ghost 2 CAPTURE
        fill_plan(4'b0001);
        pulse_cnt = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_respawn_g1_moved", int'(ghost_x[21:11]), 321);
        respawn = 1'b1;
        @(negedge clk);
        respawn = 1'b0;
        model_home();
        chk("respawn_busy", busy, 0);
        chk("respawn_done", done, 0);
        chk_all("respawn");
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("respawn_no_done", dn, 0);
        chk_all("respawn_quiet");
        run_sweep(1'b1);

        // Reset asserted mid-sweep
        do_respawn();
        fill_plan(4'b0100);
        pulse_cnt = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        model_home();
        chk("arst_busy", busy, 0);
        chk("arst_eng_step", eng_step, 0);
        chk_all("arst");
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("arst_no_done", dn, 0);
        run_sweep(1'b1);

        // Clamp at x=0 and x=X_MAX
        do_respawn();
        fill_plan(4'b1000);
        repeat (310) run_sweep(1'b0);
        chk("clamp_left_x0", int'(ghost_x[10:0]), 0);
        chk("clamp_left_d0", int'(ghost_dir[3:0]), 8);
        chk_all("clamp_left");
        do_respawn();
        fill_plan(4'b0001);
        repeat (290) run_sweep(1'b0);
        chk("clamp_right_x3", int'(ghost_x[43:33]), XM);
        chk_all("clamp_right");

        // Random directions and pacman positions
        do_respawn();
        for (int it = 0; it < 40; it++) begin
            for (int g = 0; g < NG; g++) begin
                case ($urandom_range(0, 5))
                    0: plan[g] = 4'b0001;
                    1: plan[g] = 4'b0010;
                    2: plan[g] = 4'b0100;
                    3: plan[g] = 4'b1000;
                    4: plan[g] = 4'b0000;
                    default: plan[g] = 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 1) == 1) begin
                int tg;
                int px;
                int py;
                tg = int'($urandom_range(0, NG - 1));
                px = mx[tg] + int'($urandom_range(0, 20)) - 10;
                py = my[tg] + int'($urandom_range(0, 20)) - 10;
                pacman_x = 11'((px < 0) ? 0 : px);
                pacman_y = 10'((py < 0) ? 0 : py);
            end else begin
                pacman_x = 11'($urandom_range(0, XM));
                pacman_y = 10'($urandom_range(0, YM));
            end
            run_sweep(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
